decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_seq_pkg.sv | 42 ++++
 rtl/decoder_seq_table.sv | 40 ++++
 rtl/decoder_seq.sv | 64 ++++++
 tb/tb_decoder_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: shared opcode, ALU, operand-mux and mode encodings for the decode sequencer
package decoder_seq_pkg;
  localparam logic [7:0] RESET_OP_DEF = 8'hEA;
  localparam logic [7:0] OP_JMP = 8'h4C;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SBC = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_EOR = 4'd4;
  localparam logic [3:0] ALU_ORA = 4'd5;
  localparam logic [3:0] ALU_PASS = 4'd11;
  localparam logic [3:0] ALU_CMP = 4'd12;
  localparam logic [1:0] MUX_X = 2'd0;
  localparam logic [1:0] MUX_Y = 2'd1;
  localparam logic [1:0] MUX_SP = 2'd2;
  localparam logic [1:0] MUX_IMM = 2'd3;
  localparam logic [2:0] AAA_STA = 3'd4;
  localparam logic [2:0] AAA_CMP = 3'd6;
  typedef enum logic [2:0] {T0, T1, T2, T3} t_state_e;
  typedef enum logic [2:0] {M_NOP, M_IMM, M_ZP, M_ABS, M_JMP} mode_e;
  typedef struct packed {
    logic sync;
    logic w_rd;
    logic pc_data;
    logic increment;
    logic addr_lo_load;
    logic addr_hi_load;
    logic accumulator_con;
    logic status_con;
    logic branch_uncon;
    logic [3:0] alu_op;
    logic [1:0] operand_mux_con;
  } ctrl_t;
  function automatic logic [3:0] alu_code(input logic [2:0] aaa);
    return aaa == 3'd0 ? ALU_ORA :
           aaa == 3'd1 ? ALU_AND :
           aaa == 3'd2 ? ALU_EOR :
           aaa == 3'd3 ? ALU_ADC :
           aaa == 3'd6 ? ALU_CMP :
           aaa == 3'd7 ? ALU_SBC : ALU_PASS;
  endfunction
endpackage

// File: rtl/decoder_seq_table.sv
// decoder_seq_table: combinational (IR, T-state) to control-word lookup with last-cycle flag
module decoder_seq_table import decoder_seq_pkg::*; (
  input  logic [7:0] ir,
  input  t_state_e   t,
  output ctrl_t      cw,
  output logic       last
);
  logic [2:0] aaa, bbb;
  logic [1:0] cc;
  mode_e mode;
  t_state_e last_t;
  logic commit;
  assign {aaa, bbb, cc} = ir;
  assign mode = ir == OP_JMP ? M_JMP :
                cc != 2'b01 ? M_NOP :
                bbb == 3'b010 ? M_IMM :
                bbb == 3'b001 ? M_ZP :
                bbb == 3'b011 ? M_ABS : M_NOP;
  assign last_t = mode == M_ABS ? T3 : (mode == M_ZP || mode == M_JMP) ? T2 : T1;
  // any state at or beyond the mode's final cycle ends the instruction, so nothing can hang
  assign last = t >= last_t;
  assign commit = last && (mode == M_IMM || mode == M_ZP || mode == M_ABS);
  always_comb begin
    cw = '0;
    cw.sync = t == T0;
    cw.pc_data = 1'b1;
    cw.increment = t == T0 || (t == T1 && mode != M_NOP) || (t == T2 && mode == M_ABS);
    cw.addr_lo_load = t == T1 && (mode == M_ZP || mode == M_ABS || mode == M_JMP);
    cw.addr_hi_load = (t == T1 && mode == M_ZP) || (t == T2 && mode == M_ABS);
    cw.branch_uncon = t == T2 && mode == M_JMP;
    if (commit) begin
      cw.pc_data = mode == M_IMM;
      cw.alu_op = alu_code(aaa);
      cw.operand_mux_con = MUX_IMM;
      cw.w_rd = aaa == AAA_STA;
      cw.status_con = aaa != AAA_STA;
      cw.accumulator_con = aaa != AAA_STA && aaa != AAA_CMP;
    end
  end
endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: opcode sequencer holding the T-state counter and IR, with stall, flush and reset gating
module decoder_seq import decoder_seq_pkg::*; #(
  parameter int DATA_W = 8,
  parameter logic [7:0] RESET_OP = RESET_OP_DEF,
  parameter int ALU_W = 4
) (
  input  logic              clk_2,
  input  logic              rst,
  input  logic              ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] instruction,
  output logic              sync,
  output logic [2:0]        t_state,
  output logic              w_rd,
  output logic              pc_data,
  output logic              increment,
  output logic              addr_lo_load,
  output logic              addr_hi_load,
  output logic              accumulator_con,
  output logic              status_con,
  output logic              branch_uncon,
  output logic [ALU_W-1:0]  alu_op,
  output logic [1:0]        operand_mux_con
);
  t_state_e t, t_nxt;
  logic [7:0] ir, ir_nxt;
  ctrl_t cw;
  logic last;
  logic unused_bus;
  assign unused_bus = ^instruction;
  decoder_seq_table u_table (.ir(ir), .t(t), .cw(cw), .last(last));
  always_ff @(posedge clk_2 or negedge rst)
    if (!rst) begin
      t <= T0;
      ir <= RESET_OP;
    end else begin
      t <= t_nxt;
      ir <= ir_nxt;
    end
  always_comb begin
    t_nxt = t;
    ir_nxt = ir;
    if (flush) begin
      t_nxt = T0;
      ir_nxt = RESET_OP;
    end else if (ready) begin
      t_nxt = t == T0 ? T1 : last ? T0 : t_state_e'(t + 3'd1);
      ir_nxt = t == T0 ? instruction[7:0] : ir;
    end
  end
  assign t_state = t;
  assign sync = cw.sync;
  assign pc_data = cw.pc_data;
  // reset only needs increment masked: the async clear already forces T0, whose other enables are 0
  assign increment = rst & ready & cw.increment;
  assign w_rd = ready & cw.w_rd;
  assign addr_lo_load = ready & cw.addr_lo_load;
  assign addr_hi_load = ready & cw.addr_hi_load;
  assign accumulator_con = ready & cw.accumulator_con;
  assign status_con = ready & cw.status_con;
  assign branch_uncon = ready & cw.branch_uncon;
  assign alu_op = ALU_W'(cw.alu_op);
  assign operand_mux_con = cw.operand_mux_con;
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed self-checking bench for the decode sequencer
module tb_decoder_seq;
  logic clk_2 = 1'b0;
  logic rst, ready, flush;
  logic [7:0] instruction;
  logic sync, w_rd, pc_data, increment, addr_lo_load, addr_hi_load;
  logic accumulator_con, status_con, branch_uncon;
  logic [2:0] t_state;
  logic [3:0] alu_op;
  logic [1:0] operand_mux_con;
  int n_run = 0, n_fail = 0;
  logic [8:0] ctl;
  // word order: sync w_rd pc_data increment lo hi acc status branch
  localparam logic [8:0] W_RST = 9'b101000000;
  localparam logic [8:0] W_T0  = 9'b101100000;
  localparam logic [8:0] W_IMM = 9'b001100110;
  localparam logic [8:0] W_CMP = 9'b001100010;
  localparam logic [8:0] W_ZP1 = 9'b001111000;
  localparam logic [8:0] W_STA = 9'b010000000;
  localparam logic [8:0] W_AB1 = 9'b001110000;
  localparam logic [8:0] W_AB2 = 9'b001101000;
  localparam logic [8:0] W_STL = 9'b001000000;
  localparam logic [8:0] W_ABC = 9'b000000110;
  localparam logic [8:0] W_J2  = 9'b001000001;
  localparam logic [8:0] W_NOP = 9'b001000000;
  always #5 clk_2 = ~clk_2;
  assign ctl = {sync, w_rd, pc_data, increment, addr_lo_load, addr_hi_load,
                accumulator_con, status_con, branch_uncon};
  decoder_seq dut (
    .clk_2(clk_2), .rst(rst), .ready(ready), .flush(flush), .instruction(instruction),
    .sync(sync), .t_state(t_state), .w_rd(w_rd), .pc_data(pc_data), .increment(increment),
    .addr_lo_load(addr_lo_load), .addr_hi_load(addr_hi_load),
    .accumulator_con(accumulator_con), .status_con(status_con), .branch_uncon(branch_uncon),
    .alu_op(alu_op), .operand_mux_con(operand_mux_con)
  );
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask
  task automatic chk(input string tag, input logic [8:0] w, input logic [2:0] t,
                     input logic [3:0] a, input logic [1:0] m);
    logic [17:0] obs, exp;
    #1;
    obs = {ctl, t_state, alu_op, operand_mux_con};
    exp = {w, t, a, m};
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed ctl=%b t=%0d alu=%0d mux=%0d expected ctl=%b t=%0d alu=%0d mux=%0d",
             tag, obs[17:9], obs[8:6], obs[5:2], obs[1:0], w, t, a, m);
    end
  endtask
  initial begin
    rst = 1'b0; ready = 1'b1; flush = 1'b0; instruction = 8'h00;
    chk("reset_word", W_RST, 3'd0, 4'd0, 2'd0);
    repeat (2) tick();
    chk("reset_held", W_RST, 3'd0, 4'd0, 2'd0);
    rst = 1'b1;
    chk("t0_after_release", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h69; tick();
    chk("adc_imm_t1", W_IMM, 3'd1, 4'd1, 2'd3);
    instruction = 8'h12; tick();
    chk("adc_imm_done", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h85; tick();
    chk("sta_zp_t1", W_ZP1, 3'd1, 4'd0, 2'd0);
    instruction = 8'h10; tick();
    chk("sta_zp_t2", W_STA, 3'd2, 4'd11, 2'd3);
    tick();
    chk("sta_zp_done", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h6D; tick();
    chk("adc_abs_t1", W_AB1, 3'd1, 4'd0, 2'd0);
    instruction = 8'h34; tick();
    ready = 1'b0;
    chk("adc_abs_stall1", W_STL, 3'd2, 4'd0, 2'd0);
    tick();
    chk("adc_abs_stall2", W_STL, 3'd2, 4'd0, 2'd0);
    ready = 1'b1;
    chk("adc_abs_t2", W_AB2, 3'd2, 4'd0, 2'd0);
    tick();
    chk("adc_abs_t3", W_ABC, 3'd3, 4'd1, 2'd3);
    tick();
    chk("adc_abs_done", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h4C; tick();
    chk("jmp_t1", W_AB1, 3'd1, 4'd0, 2'd0);
    tick();
    chk("jmp_t2", W_J2, 3'd2, 4'd0, 2'd0);
    tick();
    chk("jmp_done", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'hC9; tick();
    chk("cmp_imm_t1", W_CMP, 3'd1, 4'd12, 2'd3);
    tick();
    chk("cmp_imm_done", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h02; tick();
    chk("nop_t1", W_NOP, 3'd1, 4'd0, 2'd0);
    tick();
    chk("nop_done", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h6D; tick();
    tick();
    flush = 1'b1;
    chk("flush_cycle_t2", W_AB2, 3'd2, 4'd0, 2'd0);
    tick();
    flush = 1'b0;
    chk("flush_to_t0", W_T0, 3'd0, 4'd0, 2'd0);
    n_run++;
    assert (dut.ir === 8'hEA) else begin
      n_fail++;
      $error("FAIL flush_ir observed=%h expected=ea", dut.ir);
    end
    instruction = 8'h02; tick();
    chk("flush_no_commit", W_NOP, 3'd1, 4'd0, 2'd0);
    tick();
    instruction = 8'h85; tick();
    tick();
    chk("sta_zp_t2_again", W_STA, 3'd2, 4'd11, 2'd3);
    rst = 1'b0;
    chk("rst_abort", W_RST, 3'd0, 4'd0, 2'd0);
    tick();
    chk("rst_abort_held", W_RST, 3'd0, 4'd0, 2'd0);
    rst = 1'b1;
    chk("rst_release_t0", W_T0, 3'd0, 4'd0, 2'd0);
    instruction = 8'h69; tick();
    chk("resume_adc_t1", W_IMM, 3'd1, 4'd1, 2'd3);
    tick();
    chk("resume_done", W_T0, 3'd0, 4'd0, 2'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
